// File: rtl/mc_control_fsm_if.sv
// Control bus between the multicycle controller and the RV64 datapath / memories.
// master = controller side, slave = datapath and memory side.
interface mc_control_fsm_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_b5;
    logic       alu_zero;
    logic       imem_ready;
    logic       dmem_ready;
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       ir_load;
    logic       pc_write;
    logic       pc_source;
    logic       a_write;
    logic       b_write;
    logic       aluout_write;
    logic       mdr_load;
    logic       reg_write;
    logic       wb_sel;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [3:0] state;
    logic       trap;
    logic [1:0] trap_cause;

    modport master (
        input  opcode, funct3, funct7_b5, alu_zero, imem_ready, dmem_ready,
        output imem_req, dmem_req, dmem_we, ir_load, pc_write, pc_source,
               a_write, b_write, aluout_write, mdr_load, reg_write, wb_sel,
               alu_src_a, alu_src_b, alu_op, state, trap, trap_cause
    );

    modport slave (
        output opcode, funct3, funct7_b5, alu_zero, imem_ready, dmem_ready,
        input  imem_req, dmem_req, dmem_we, ir_load, pc_write, pc_source,
               a_write, b_write, aluout_write, mdr_load, reg_write, wb_sel,
               alu_src_a, alu_src_b, alu_op, state, trap, trap_cause
    );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle RV64 control FSM with req/ready memory handshakes, wait timeout and sticky trap.
// Optional MC_PERF_CNT_EN adds cycle_cnt / instret_cnt performance counters.
module mc_control_fsm #(
    parameter int MEM_TIMEOUT = 15
`ifdef MC_PERF_CNT_EN
    , parameter int CNT_W = 32
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    mc_control_fsm_if.master     bus
`ifdef MC_PERF_CNT_EN
    , output logic [CNT_W-1:0]   cycle_cnt
    , output logic [CNT_W-1:0]   instret_cnt
`endif
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        WB_ALU   = 4'd4,
        MEM_ADDR = 4'd5,
        MEM_RD   = 4'd6,
        WB_MEM   = 4'd7,
        MEM_WR   = 4'd8,
        BRANCH   = 4'd9,
        TRAP     = 4'd10
    } state_t;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_SD = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b110;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     curState, nextState;
    logic [1:0] trapCause, nextCause;
    logic [7:0] waitCnt;
    logic       memWait, waitHit;

    // A wait cycle is one where the active request sees no ready.
    assign memWait = ((curState == FETCH) && !bus.imem_ready) ||
                     (((curState == MEM_RD) || (curState == MEM_WR)) && !bus.dmem_ready);
    assign waitHit = (waitCnt == WAIT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            curState  <= FETCH;
            trapCause <= 2'b00;
            waitCnt   <= 8'd0;
        end else begin
            curState  <= nextState;
            trapCause <= nextCause;
            waitCnt   <= (memWait && (nextState == curState)) ? waitCnt + 8'd1 : 8'd0;
        end
    end

    always_comb begin
        nextState = curState;
        nextCause = trapCause;
        case (curState)
            FETCH: begin
                if (bus.imem_ready) nextState = DECODE;
                else if (waitHit) begin
                    nextState = TRAP;
                    nextCause = 2'b10;
                end
            end
            DECODE: begin
                case (bus.opcode)
                    OP_R:         nextState = EXEC_R;
                    OP_I:         nextState = EXEC_I;
                    OP_LD, OP_SD: nextState = MEM_ADDR;
                    OP_BR:        nextState = (bus.funct3[2:1] == 2'b00) ? BRANCH : TRAP;
                    default:      nextState = TRAP;
                endcase
                if (nextState == TRAP) nextCause = 2'b01;
            end
            EXEC_R, EXEC_I:   nextState = WB_ALU;
            WB_ALU, WB_MEM:   nextState = FETCH;
            MEM_ADDR:         nextState = (bus.opcode == OP_LD) ? MEM_RD : MEM_WR;
            MEM_RD, MEM_WR: begin
                if (bus.dmem_ready) nextState = (curState == MEM_RD) ? WB_MEM : FETCH;
                else if (waitHit) begin
                    nextState = TRAP;
                    nextCause = 2'b11;
                end
            end
            BRANCH:           nextState = FETCH;
            TRAP:             nextState = TRAP;
            default:          nextState = FETCH;
        endcase
    end

    // Outputs are forced low while reset is held so requests drop without a clock edge.
    always_comb begin
        bus.imem_req     = 1'b0;
        bus.dmem_req     = 1'b0;
        bus.dmem_we      = 1'b0;
        bus.ir_load      = 1'b0;
        bus.pc_write     = 1'b0;
        bus.pc_source    = 1'b0;
        bus.a_write      = 1'b0;
        bus.b_write      = 1'b0;
        bus.aluout_write = 1'b0;
        bus.mdr_load     = 1'b0;
        bus.reg_write    = 1'b0;
        bus.wb_sel       = 1'b0;
        bus.alu_src_a    = 1'b0;
        bus.alu_src_b    = 2'b00;
        bus.alu_op       = 3'b000;
        bus.trap         = 1'b0;
        bus.state        = curState;
        bus.trap_cause   = trapCause;
        if (!reset) begin
            case (curState)
                FETCH: begin
                    bus.imem_req  = 1'b1;
                    bus.alu_src_b = 2'b01;
                    bus.alu_op    = ALU_ADD;
                    bus.ir_load   = bus.imem_ready;
                    bus.pc_write  = bus.imem_ready;
                end
                DECODE: begin
                    bus.a_write      = 1'b1;
                    bus.b_write      = 1'b1;
                    bus.aluout_write = 1'b1;
                    bus.alu_src_b    = 2'b11;
                    bus.alu_op       = ALU_ADD;
                end
                EXEC_R: begin
                    bus.alu_src_a    = 1'b1;
                    bus.aluout_write = 1'b1;
                    if (bus.funct3 == 3'b111)      bus.alu_op = ALU_AND;
                    else if (bus.funct3 == 3'b100) bus.alu_op = ALU_XOR;
                    else                           bus.alu_op = bus.funct7_b5 ? ALU_SUB : ALU_ADD;
                end
                EXEC_I, MEM_ADDR: begin
                    bus.alu_src_a    = 1'b1;
                    bus.alu_src_b    = 2'b10;
                    bus.alu_op       = ALU_ADD;
                    bus.aluout_write = 1'b1;
                end
                WB_ALU: bus.reg_write = 1'b1;
                MEM_RD: begin
                    bus.dmem_req = 1'b1;
                    bus.mdr_load = bus.dmem_ready;
                end
                WB_MEM: begin
                    bus.reg_write = 1'b1;
                    bus.wb_sel    = 1'b1;
                end
                MEM_WR: begin
                    bus.dmem_req = 1'b1;
                    bus.dmem_we  = 1'b1;
                end
                BRANCH: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_op    = ALU_SUB;
                    bus.pc_source = 1'b1;
                    bus.pc_write  = bus.alu_zero ^ bus.funct3[0];
                end
                TRAP:    bus.trap = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef MC_PERF_CNT_EN
    logic retire;
    assign retire = (curState == WB_ALU) || (curState == WB_MEM) || (curState == BRANCH) ||
                    ((curState == MEM_WR) && bus.dmem_ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (curState != TRAP) cycle_cnt <= cycle_cnt + 1'b1;
            if (retire)           instret_cnt <= instret_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: each instruction is expanded into its expected per-cycle
// trace (from the instruction-level timing rules) and replayed against the DUT.
module tb_mc_control_fsm;
    localparam int TMO = 15;
    localparam logic [2:0] ADD = 3'b001, SUB = 3'b010, AND_ = 3'b011, XOR_ = 3'b110;
    localparam int K_R = 0, K_I = 1, K_LD = 2, K_SD = 3, K_BR = 4, K_ILL = 5;

    typedef struct packed {
        logic [3:0] st;
        logic ireq, dreq, we, irl, pcw, pcs, aw, bw, aluw, mdr, rw, wbs, srca;
        logic [1:0] srcb;
        logic [2:0] op;
        logic trap;
        logic [1:0] cause;
    } obs_t;

    typedef struct {
        logic [6:0] op7;
        logic [2:0] f3;
        logic       f7, ir, dr, z;
    } stim_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    mc_control_fsm_if bus ();
    obs_t  exp_q[$];
    stim_t stim_q[$];
    int checks = 0, errors = 0;
    int expCyc = 0, expRet = 0;

`ifdef MC_PERF_CNT_EN
    logic [31:0] cycleCnt, instretCnt;
    mc_control_fsm #(.MEM_TIMEOUT(TMO), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .bus(bus), .cycle_cnt(cycleCnt), .instret_cnt(instretCnt));
`else
    mc_control_fsm #(.MEM_TIMEOUT(TMO)) dut (.clk(clk), .reset(reset), .bus(bus));
`endif

    always #5 clk = ~clk;

    function automatic obs_t sample();
        obs_t o;
        o.st = bus.state;       o.ireq = bus.imem_req;  o.dreq = bus.dmem_req;
        o.we = bus.dmem_we;     o.irl = bus.ir_load;    o.pcw = bus.pc_write;
        o.pcs = bus.pc_source;  o.aw = bus.a_write;     o.bw = bus.b_write;
        o.aluw = bus.aluout_write; o.mdr = bus.mdr_load; o.rw = bus.reg_write;
        o.wbs = bus.wb_sel;     o.srca = bus.alu_src_a; o.srcb = bus.alu_src_b;
        o.op = bus.alu_op;      o.trap = bus.trap;      o.cause = bus.trap_cause;
        return o;
    endfunction

    task automatic push(input obs_t e, input stim_t s);
        exp_q.push_back(e);
        stim_q.push_back(s);
    endtask

    task automatic push_trap(input logic [1:0] cause, input stim_t s);
        obs_t e;
        for (int i = 0; i < 22; i++) begin
            e = '0; e.st = 4'd10; e.trap = 1'b1; e.cause = cause;
            s.ir = 1'($urandom_range(0, 1)); s.dr = 1'($urandom_range(0, 1));
            s.z = 1'($urandom_range(0, 1));
            push(e, s);
        end
    endtask

    // Expand one instruction into its cycle trace. iw/dw = wait cycles before ready
    // (-1 or >= TMO: ready never comes in time). zv < 0 picks alu_zero at random.
    task automatic plan(input int kind, input logic [2:0] f3, input logic f7,
                        input int iw, input int dw, input int zv);
        obs_t e; stim_t s;
        case (kind)
            K_R:  s.op7 = 7'b0110011;
            K_I:  s.op7 = 7'b0010011;
            K_LD: s.op7 = 7'b0000011;
            K_SD: s.op7 = 7'b0100011;
            K_BR: s.op7 = 7'b1100011;
            default: s.op7 = 7'b1111111;
        endcase
        s.f3 = f3; s.f7 = f7;
        for (int k = 0; ; k++) begin
            e = '0; e.ireq = 1'b1; e.srcb = 2'b01; e.op = ADD;
            s.ir = (k == iw); s.dr = 1'($urandom_range(0, 1)); s.z = 1'($urandom_range(0, 1));
            if (s.ir) begin e.irl = 1'b1; e.pcw = 1'b1; end
            push(e, s);
            if (s.ir) break;
            if (k == TMO - 1) begin push_trap(2'b10, s); return; end
        end
        s.ir = 1'($urandom_range(0, 1)); s.dr = 1'($urandom_range(0, 1));
        e = '0; e.st = 4'd1; e.aw = 1'b1; e.bw = 1'b1; e.aluw = 1'b1; e.srcb = 2'b11; e.op = ADD;
        push(e, s);
        if (kind == K_ILL || (kind == K_BR && f3[2:1] != 2'b00)) begin
            push_trap(2'b01, s);
            return;
        end
        case (kind)
            K_R, K_I: begin
                e = '0; e.srca = 1'b1; e.aluw = 1'b1;
                if (kind == K_I) begin e.st = 4'd3; e.srcb = 2'b10; e.op = ADD; end
                else begin
                    e.st = 4'd2;
                    e.op = (f3 == 3'b111) ? AND_ : (f3 == 3'b100) ? XOR_ : (f7 ? SUB : ADD);
                end
                push(e, s);
                e = '0; e.st = 4'd4; e.rw = 1'b1; push(e, s);
            end
            K_LD, K_SD: begin
                e = '0; e.st = 4'd5; e.srca = 1'b1; e.srcb = 2'b10; e.op = ADD; e.aluw = 1'b1;
                push(e, s);
                for (int k = 0; ; k++) begin
                    e = '0; e.dreq = 1'b1;
                    e.st = (kind == K_LD) ? 4'd6 : 4'd8; e.we = (kind == K_SD);
                    s.dr = (k == dw); s.ir = 1'($urandom_range(0, 1));
                    e.mdr = (kind == K_LD) && s.dr;
                    push(e, s);
                    if (s.dr) break;
                    if (k == TMO - 1) begin push_trap(2'b11, s); return; end
                end
                if (kind == K_LD) begin
                    e = '0; e.st = 4'd7; e.rw = 1'b1; e.wbs = 1'b1; push(e, s);
                end
            end
            default: begin
                s.z = (zv < 0) ? 1'($urandom_range(0, 1)) : 1'(zv);
                e = '0; e.st = 4'd9; e.srca = 1'b1; e.op = SUB; e.pcs = 1'b1;
                e.pcw = s.z ^ f3[0];
                push(e, s);
            end
        endcase
    endtask

    // Replays up to n queued cycles (n < 0: all). Entered and left at posedge+1.
    task automatic play(input string name, input int n);
        obs_t e, got; stim_t s; int idx = 0;
        while (exp_q.size() > 0 && (n < 0 || idx < n)) begin
            e = exp_q.pop_front(); s = stim_q.pop_front();
            bus.opcode = s.op7; bus.funct3 = s.f3; bus.funct7_b5 = s.f7;
            bus.imem_ready = s.ir; bus.dmem_ready = s.dr; bus.alu_zero = s.z;
            @(negedge clk);
            got = sample();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL %s cycle %0d: got state=%0d bits=%h, expected state=%0d bits=%h",
                         name, idx, got.st, got, e.st, e);
            end
`ifdef MC_PERF_CNT_EN
            checks++;
            if (cycleCnt !== 32'(expCyc) || instretCnt !== 32'(expRet)) begin
                errors++;
                $display("FAIL %s perf cycle %0d: got cyc=%0d ret=%0d, expected cyc=%0d ret=%0d",
                         name, idx, cycleCnt, instretCnt, expCyc, expRet);
            end
`endif
            if (e.st != 4'd10) expCyc++;
            if (e.st == 4'd4 || e.st == 4'd7 || e.st == 4'd9 || (e.st == 4'd8 && s.dr)) expRet++;
            @(posedge clk); #1;
            idx++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete(); stim_q.delete();
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        expCyc = 0; expRet = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.opcode = 7'b0110011; bus.funct3 = 3'b000; bus.funct7_b5 = 1'b0;
        bus.imem_ready = 1'b1; bus.dmem_ready = 1'b1; bus.alu_zero = 1'b1;
        @(negedge clk);
        checks++;
        if (sample() !== obs_t'('0)) begin
            errors++;
            $display("FAIL reset_outputs: got %h, expected 0", sample());
        end
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        checks++;
        if (bus.imem_req !== 1'b1 || bus.state !== 4'd0) begin
            errors++;
            $display("FAIL reset_release: got imem_req=%b state=%0d, expected 1/0", bus.imem_req, bus.state);
        end
        expCyc = 0; expRet = 0;
    endtask

    task automatic test_add();
        plan(K_R, 3'b000, 1'b0, 0, 0, -1);
        play("add", -1);
    endtask

    task automatic test_ld_wait();
        plan(K_LD, 3'b011, 1'b0, 0, 3, -1);
        play("ld_wait", -1);
        plan(K_SD, 3'b011, 1'b0, 2, 0, -1);
        play("sd", -1);
    endtask

    task automatic test_branch();
        plan(K_BR, 3'b000, 1'b0, 0, 0, 1);
        plan(K_BR, 3'b001, 1'b0, 0, 0, 1);
        plan(K_BR, 3'b000, 1'b0, 1, 0, 0);
        plan(K_BR, 3'b001, 1'b0, 0, 0, 0);
        play("branch", -1);
    endtask

    task automatic test_illegal();
        plan(K_ILL, 3'b000, 1'b0, 0, 0, -1);
        play("illegal_opcode", -1);
        do_reset();
        plan(K_BR, 3'b010, 1'b0, 1, 0, -1);
        play("illegal_br_funct3", -1);
        do_reset();
    endtask

    task automatic test_timeout();
        plan(K_R, 3'b000, 1'b0, -1, 0, -1);
        play("imem_timeout", -1);
        do_reset();
        plan(K_I, 3'b000, 1'b0, TMO - 1, 0, -1);
        play("imem_ready_at_limit", -1);
        plan(K_LD, 3'b011, 1'b0, 0, -1, -1);
        play("dmem_timeout", -1);
        do_reset();
        plan(K_SD, 3'b011, 1'b0, 0, TMO - 1, -1);
        play("dmem_ready_at_limit", -1);
    endtask

    task automatic test_random();
        int kind;
        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 4);
            plan(kind, (kind == K_BR) ? 3'($urandom_range(0, 1)) : 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) == 0) ? 13 : $urandom_range(0, 3),
                 ($urandom_range(0, 9) == 0) ? 12 : $urandom_range(0, 3), -1);
        end
        play("random", -1);
    endtask

    task automatic test_reset_mid();
        plan(K_SD, 3'b011, 1'b0, 0, 10, -1);
        play("reset_mid_pre", 6);
        bus.dmem_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        checks++;
        if (sample() !== obs_t'('0)) begin
            errors++;
            $display("FAIL reset_mid_async: got %h, expected 0", sample());
        end
`ifdef MC_PERF_CNT_EN
        checks++;
        if (cycleCnt !== 32'd0 || instretCnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_perf: got cyc=%0d ret=%0d, expected 0/0", cycleCnt, instretCnt);
        end
`endif
        exp_q.delete(); stim_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        expCyc = 0; expRet = 0;
        #1;
        checks++;
        if (bus.imem_req !== 1'b1 || bus.state !== 4'd0) begin
            errors++;
            $display("FAIL reset_mid_release: got imem_req=%b state=%0d, expected 1/0", bus.imem_req, bus.state);
        end
        plan(K_R, 3'b111, 1'b1, 1, 0, -1);
        play("after_reset_mid", -1);
    endtask

    initial begin
        test_reset();
        test_add();
        test_ld_wait();
        test_branch();
        test_illegal();
        test_timeout();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
